// File: rtl/seq_monitor_pkg.sv
// Shared types and constants for the sequencer monitor: FSM encoding and
// the fixed segment patterns used when the display is not showing a digit.
package seq_monitor_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } fsm_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to 7-segment decoder, segments {g,f,e,d,c,b,a}
// active-high. The caller registers the result.
module hex_to_seg7 (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h00;
      case (nibble)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/seq_monitor.sv
// Checks each step of a 4-bit state sequencer against a successor table,
// counts illegal steps and wraps, detects a stuck sequencer, drives a display.
module seq_monitor
   import seq_monitor_pkg::*;
#(
   parameter logic [63:0] NEXT_TABLE  = 64'h0FEDCBA987654321,
   parameter logic [3:0]  START_STATE = 4'd0,
   parameter int          ERR_LIMIT   = 16,
   parameter int          STUCK_LIMIT = 8,
   parameter int          ERR_W       = 8
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic [3:0]       State,
   output logic             Synced,
   output logic             Mismatch,
   output logic             Fault,
   output logic             Stuck,
   output logic [ERR_W-1:0] ErrCnt,
   output logic [7:0]       WrapCnt,
   output logic [6:0]       Seg
);

   localparam int               REP_W   = $clog2(STUCK_LIMIT + 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   fsm_t             fsm_q, fsm_d;
   logic [3:0]       prev_q;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [3:0]       exp_state;
   logic [6:0]       seg_hex;
   logic [6:0]       seg_d;
   logic             mis_d;
   logic             stuck_d;
   logic [ERR_W-1:0] err_d;
   logic [7:0]       wrap_d;

   hex_to_seg7 u_hex (
      .nibble (State),
      .seg    (seg_hex)
   );

   // prev_q indexes a 4-bit slot of the packed table
   assign exp_state = NEXT_TABLE[{prev_q, 2'b00} +: 4];

   always_comb begin
      fsm_d   = fsm_q;
      rep_d   = rep_q;
      err_d   = ErrCnt;
      wrap_d  = WrapCnt;
      stuck_d = Stuck;
      mis_d   = 1'b0;
      seg_d   = seg_hex;
      case (fsm_q)
         SYNC: begin
            rep_d = '0;
            if (State == START_STATE) fsm_d = TRACK;
         end
         TRACK: begin
            if (State != exp_state) begin
               mis_d = 1'b1;
               if (ErrCnt != ERR_MAX) err_d = ErrCnt + 1'b1;
            end else if (State == START_STATE) begin
               wrap_d = WrapCnt + 1'b1;
            end
            rep_d = (State == prev_q) ? rep_q + 1'b1 : '0;
            // Stuck and error-limit exits may fire together; both take effect
            if (rep_d == REP_W'(STUCK_LIMIT)) begin
               stuck_d = 1'b1;
               fsm_d   = FAULT;
            end
            if (mis_d && (err_d == ERR_W'(ERR_LIMIT))) fsm_d = FAULT;
         end
         FAULT: begin
            fsm_d = FAULT;
         end
         default: begin
            fsm_d = SYNC;
         end
      endcase
      if (fsm_d == FAULT) seg_d = SEG_DASH;
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         fsm_q    <= SYNC;
         prev_q   <= 4'd0;
         rep_q    <= '0;
         Synced   <= 1'b0;
         Mismatch <= 1'b0;
         Fault    <= 1'b0;
         Stuck    <= 1'b0;
         ErrCnt   <= '0;
         WrapCnt  <= 8'd0;
         Seg      <= SEG_BLANK;
      end else begin
         fsm_q    <= fsm_d;
         prev_q   <= State;
         rep_q    <= rep_d;
         Synced   <= (fsm_d == TRACK);
         Mismatch <= mis_d;
         Fault    <= (fsm_d == FAULT);
         Stuck    <= stuck_d;
         ErrCnt   <= err_d;
         WrapCnt  <= wrap_d;
         Seg      <= seg_d;
      end
   end

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench for seq_monitor: stimulus feeds a behavioural model that
// queues expected outputs; an independent monitor pops and compares each cycle.
module tb_seq_monitor;

   logic       Clk = 1'b0;
   logic       Clr = 1'b1;
   logic [3:0] State = 4'd0;
   logic       Synced, Mismatch, Fault, Stuck;
   logic [7:0] ErrCnt, WrapCnt;
   logic [6:0] Seg;

   seq_monitor dut (
      .Clk      (Clk),
      .Clr      (Clr),
      .State    (State),
      .Synced   (Synced),
      .Mismatch (Mismatch),
      .Fault    (Fault),
      .Stuck    (Stuck),
      .ErrCnt   (ErrCnt),
      .WrapCnt  (WrapCnt),
      .Seg      (Seg)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       synced;
      logic       mis;
      logic       fault;
      logic       stuck;
      logic [7:0] err;
      logic [7:0] wrap;
      logic [6:0] seg;
   } exp_t;

   exp_t expq[$];
   int   vectors = 0;
   int   miscompares = 0;

   logic [6:0] hex_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: 0=waiting for start, 1=tracking, 2=faulted
   int m_mode = 0, m_prev = 0, m_rep = 0, m_err = 0, m_wrap = 0;
   bit m_stuck = 0;
   int cur = 0;

   task automatic apply(input logic clr, input logic [3:0] st);
      exp_t e;
      int   succ;
      bit   bad;
      @(negedge Clk);
      Clr   = clr;
      State = st;
      @(posedge Clk);
      e   = '0;
      bad = 1'b0;
      if (clr) begin
         m_mode = 0; m_prev = 0; m_rep = 0; m_err = 0; m_wrap = 0; m_stuck = 0;
      end else begin
         succ = (m_prev + 1) % 16;
         if (m_mode == 0) begin
            m_rep = 0;
            if (int'(st) == 0) m_mode = 1;
         end else if (m_mode == 1) begin
            bad = (int'(st) != succ);
            if (bad) m_err = (m_err < 255) ? m_err + 1 : 255;
            else if (int'(st) == 0) m_wrap = (m_wrap + 1) % 256;
            m_rep = (int'(st) == m_prev) ? m_rep + 1 : 0;
            if (m_rep >= 8) begin
               m_stuck = 1;
               m_mode  = 2;
            end
            if (bad && m_err >= 16) m_mode = 2;
         end
         m_prev   = int'(st);
         e.synced = (m_mode == 1);
         e.mis    = bad;
         e.fault  = (m_mode == 2);
         e.stuck  = m_stuck;
         e.err    = 8'(m_err);
         e.wrap   = 8'(m_wrap);
         e.seg    = (m_mode == 2) ? 7'h40 : hex_lut[st];
      end
      expq.push_back(e);
      cur = int'(st);
   endtask

   initial begin : monitor
      exp_t e;
      exp_t got;
      forever begin
         @(posedge Clk);
         #1;
         if (expq.size() > 0) begin
            e   = expq.pop_front();
            got = '{Synced, Mismatch, Fault, Stuck, ErrCnt, WrapCnt, Seg};
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL vec%0d got syn=%b mis=%b flt=%b stk=%b err=%0d wrap=%0d seg=%h required syn=%b mis=%b flt=%b stk=%b err=%0d wrap=%0d seg=%h",
                        vectors, got.synced, got.mis, got.fault, got.stuck, got.err, got.wrap, got.seg,
                        e.synced, e.mis, e.fault, e.stuck, e.err, e.wrap, e.seg);
            end
         end
      end
   end

   initial begin : stimulus
      int v;
      // Reset with a non-start state on the bus
      apply(1'b1, 4'd9);
      apply(1'b1, 4'd9);
      // Sync on 0, then two full wraps
      for (int s = 5; s <= 15; s++) apply(1'b0, 4'(s));
      apply(1'b0, 4'd0);
      for (int i = 1; i <= 32; i++) apply(1'b0, 4'(i % 16));
      // Single glitch 4 -> 9, then 10 accepted
      for (int s = 1; s <= 4; s++) apply(1'b0, 4'(s));
      apply(1'b0, 4'd9);
      apply(1'b0, 4'd10);
      // Random legal walk with sparse glitches
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) apply(1'b0, 4'($urandom_range(0, 15)));
         else apply(1'b0, 4'((cur + 1) % 16));
      end
      // Error limit: 16 illegal non-repeating steps, then legal input while faulted
      apply(1'b1, 4'd3);
      apply(1'b0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         do v = int'($urandom_range(0, 15)); while (v == (cur + 1) % 16 || v == cur);
         apply(1'b0, 4'(v));
      end
      for (int i = 0; i < 5; i++) apply(1'b0, 4'((cur + 1) % 16));
      // Stuck: 7 held for 9 samples
      apply(1'b1, 4'd0);
      for (int s = 0; s <= 6; s++) apply(1'b0, 4'(s));
      for (int i = 0; i < 9; i++) apply(1'b0, 4'd7);
      for (int i = 0; i < 3; i++) apply(1'b0, 4'd8);
      // Clear from FAULT and resync
      apply(1'b1, 4'd7);
      apply(1'b0, 4'd0);
      apply(1'b0, 4'd1);
      apply(1'b0, 4'd2);
      // Fully random traffic with occasional clears
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 59) == 0) apply(1'b1, 4'($urandom_range(0, 15)));
         else if ($urandom_range(0, 2) == 0) apply(1'b0, 4'($urandom_range(0, 15)));
         else if ($urandom_range(0, 7) == 0) apply(1'b0, 4'(cur));
         else apply(1'b0, 4'((cur + 1) % 16));
      end
      repeat (3) @(posedge Clk);
      #2;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending required 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
